// File: rtl/ro_freq_meter_if.sv
// Handshake bundle between the management-side controller (master) and the
// ring-oscillator frequency meter (slave). Optional cont_mode lane exists only
// when RO_CONT_MODE_EN is defined.
interface ro_freq_meter_if #(
    parameter int unsigned SEL_W  = 3,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned GATE_W = 16
);
    logic [SEL_W-1:0]  ch_sel;
    logic [GATE_W-1:0] gate_cycles;
    logic              start_req;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count;
    logic              overflow;
`ifdef RO_CONT_MODE_EN
    logic              cont_mode;

    modport master (
        output ch_sel, gate_cycles, start_req, cont_mode,
        input  busy, done, count, overflow
    );
    modport slave (
        input  ch_sel, gate_cycles, start_req, cont_mode,
        output busy, done, count, overflow
    );
`else
    modport master (
        output ch_sel, gate_cycles, start_req,
        input  busy, done, count, overflow
    );
    modport slave (
        input  ch_sel, gate_cycles, start_req,
        output busy, done, count, overflow
    );
`endif
endinterface

// File: rtl/ro_freq_meter.sv
// Gated ring-oscillator frequency meter. Enables the oscillator bank, lets it
// settle, counts rising edges of one synchronised tap over a programmable
// window of wb_clk_i cycles and returns a saturating count.
// Optional feature macro: RO_CONT_MODE_EN (back-to-back windows via cont_mode).
module ro_freq_meter #(
    parameter int unsigned NUM_CH     = 5,
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned GATE_W     = 16,
    parameter int unsigned SETTLE_CYC = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [NUM_CH-1:0] ro_in,
    output logic              ro_start,
    ro_freq_meter_if.slave    bus
);
    localparam int unsigned SetW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StSettle  = 2'd1;
    localparam logic [1:0] StMeasure = 2'd2;
    localparam logic [1:0] StDone    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [SEL_W-1:0]  ch_sel_q;
    logic [GATE_W-1:0] gate_q;
    logic [GATE_W-1:0] gate_cnt_q;
    logic [SetW-1:0]   settle_cnt_q;
    logic [CNT_W-1:0]  edge_cnt_q;
    logic [CNT_W-1:0]  count_q;
    logic              ovf_flag_q;
    logic              overflow_q;
    logic              done_q;
    logic              ro_start_q;
    logic              sync1_q, sync2_q, sync3_q;
    logic              ro_sel;
    logic              rise;
    logic              cont;
    logic              settle_last;
    logic              gate_last;

`ifdef RO_CONT_MODE_EN
    assign cont = bus.cont_mode;
`else
    assign cont = 1'b0;
`endif

    assign rise        = sync2_q & ~sync3_q;
    assign settle_last = (settle_cnt_q == SetW'(SETTLE_CYC - 1));
    assign gate_last   = (gate_cnt_q == gate_q - GATE_W'(1));

    // Tap mux; selections beyond NUM_CH read as constant 0.
    always_comb begin
        ro_sel = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel_q == SEL_W'(i)) ro_sel = ro_in[i];
        end
    end

    // Two-flop synchroniser plus one delay stage for edge detection.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= ro_sel;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (bus.start_req) state_d = StSettle;
            StSettle:  if (settle_last) state_d = (gate_q == '0) ? StDone : StMeasure;
            StMeasure: if (gate_last) state_d = StDone;
            StDone: begin
                if (cont) state_d = (bus.gate_cycles == '0) ? StDone : StMeasure;
                else      state_d = StIdle;
            end
            default:   state_d = StIdle;
        endcase
    end

    // State register, window counters and result registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= StIdle;
            ch_sel_q     <= '0;
            gate_q       <= '0;
            gate_cnt_q   <= '0;
            settle_cnt_q <= '0;
            edge_cnt_q   <= '0;
            count_q      <= '0;
            ovf_flag_q   <= 1'b0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
            ro_start_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start_req) begin
                        ch_sel_q     <= bus.ch_sel;
                        gate_q       <= bus.gate_cycles;
                        settle_cnt_q <= '0;
                        ro_start_q   <= 1'b1;
                    end
                end
                StSettle: begin
                    settle_cnt_q <= settle_cnt_q + SetW'(1);
                    gate_cnt_q   <= '0;
                    edge_cnt_q   <= '0;
                    ovf_flag_q   <= 1'b0;
                end
                StMeasure: begin
                    gate_cnt_q <= gate_cnt_q + GATE_W'(1);
                    if (rise) begin
                        if (edge_cnt_q == '1) ovf_flag_q <= 1'b1;
                        else                  edge_cnt_q <= edge_cnt_q + CNT_W'(1);
                    end
                end
                StDone: begin
                    count_q    <= edge_cnt_q;
                    overflow_q <= ovf_flag_q;
                    done_q     <= 1'b1;
                    if (cont) begin
                        // Next window starts immediately; oscillator stays enabled.
                        ch_sel_q   <= bus.ch_sel;
                        gate_q     <= bus.gate_cycles;
                        gate_cnt_q <= '0;
                        edge_cnt_q <= '0;
                        ovf_flag_q <= 1'b0;
                    end else begin
                        ro_start_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ro_start     = ro_start_q;
    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = done_q;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed bench for ro_freq_meter: one 16-bit-count instance and one 4-bit-count
// instance sharing clock, reset and clock-derived oscillator taps.
module tb_ro_freq_meter;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] phase = 4'd0;
    logic [4:0] ro;
    logic       ro_start_a, ro_start_b;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc;
    int         dones;

    ro_freq_meter_if #(.SEL_W(3), .CNT_W(16), .GATE_W(16)) bus_a ();
    ro_freq_meter_if #(.SEL_W(3), .CNT_W(4),  .GATE_W(16)) bus_b ();

    ro_freq_meter #(.NUM_CH(5), .SEL_W(3), .CNT_W(16), .GATE_W(16), .SETTLE_CYC(8)) u_dut_a (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .ro_in    (ro),
        .ro_start (ro_start_a),
        .bus      (bus_a)
    );

    ro_freq_meter #(.NUM_CH(5), .SEL_W(3), .CNT_W(4), .GATE_W(16), .SETTLE_CYC(8)) u_dut_b (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .ro_in    (ro),
        .ro_start (ro_start_b),
        .bus      (bus_b)
    );

    always #5 clk = ~clk;

    // Taps: [0]=clk/4, [1]=clk/16, [2]=clk/8, [3]=clk/4, [4]=clk/8.
    always @(negedge clk) phase <= phase + 4'd1;
    assign ro = {phase[2], phase[1], phase[2], phase[3], phase[1]};

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Count posedges until done is seen; called at a negedge.
    task automatic wait_done(input bit use_b, output int n);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            bus_a.start_req = 1'b0;
            bus_b.start_req = 1'b0;
            if (use_b ? bus_b.done : bus_a.done) break;
        end
    endtask

    task automatic measure(input bit use_b, input int sel, input int gate, output int n);
        if (use_b) begin
            bus_b.ch_sel = 3'(sel); bus_b.gate_cycles = 16'(gate); bus_b.start_req = 1'b1;
        end else begin
            bus_a.ch_sel = 3'(sel); bus_a.gate_cycles = 16'(gate); bus_a.start_req = 1'b1;
        end
        wait_done(use_b, n);
    endtask

    // Count done pulses of instance A over a number of cycles.
    task automatic count_dones(input int ncyc, output int d);
        d = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            @(negedge clk);
            bus_a.start_req = 1'b0;
            if (bus_a.done) d++;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus_a.ch_sel = '0; bus_a.gate_cycles = '0; bus_a.start_req = 1'b0;
        bus_b.ch_sel = '0; bus_b.gate_cycles = '0; bus_b.start_req = 1'b0;
`ifdef RO_CONT_MODE_EN
        bus_a.cont_mode = 1'b0;
        bus_b.cont_mode = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_ro_start", ro_start_a, 0);
        chk("rst_busy", bus_a.busy, 0);
        chk("rst_done", bus_a.done, 0);
        chk("rst_count", bus_a.count, 0);
        chk("rst_overflow", bus_a.overflow, 0);
        rst = 1'b0;

        // Start right after reset release: ro_start one cycle later.
        bus_a.ch_sel = 3'd2; bus_a.gate_cycles = 16'd64; bus_a.start_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_a.start_req = 1'b0;
        chk("ro_start_on", ro_start_a, 1);
        chk("busy_on", bus_a.busy, 1);
        wait_done(1'b0, cyc);
        chk("lat_g64", cyc + 1, 74);
        chk("count_clk8", bus_a.count, 8);
        chk("ovf_clk8", bus_a.overflow, 0);
        chk("ro_start_off", ro_start_a, 0);
        chk("busy_off", bus_a.busy, 0);

        // Saturation on the 4-bit instance, then a clean run clears overflow.
        measure(1'b1, 0, 200, cyc);
        chk("lat_g200", cyc, 210);
        chk("sat_count", bus_b.count, 15);
        chk("sat_ovf", bus_b.overflow, 1);
        measure(1'b1, 0, 8, cyc);
        chk("lat_g8", cyc, 18);
        chk("small_count", bus_b.count, 2);
        chk("small_ovf", bus_b.overflow, 0);

        // Zero-length window.
        measure(1'b0, 2, 0, cyc);
        chk("lat_g0", cyc, 10);
        chk("count_g0", bus_a.count, 0);

        // Channel select: tap 1 is clk/16, tap 7 does not exist.
        measure(1'b0, 1, 64, cyc);
        chk("count_clk16", bus_a.count, 4);
        measure(1'b0, 7, 64, cyc);
        chk("count_sel7", bus_a.count, 0);

        // start_req pulsed mid-measurement is ignored.
        bus_a.ch_sel = 3'd2; bus_a.gate_cycles = 16'd64; bus_a.start_req = 1'b1;
        dones = 0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk);
            @(negedge clk);
            bus_a.start_req = (i == 30);
            if (bus_a.done) dones++;
        end
        chk("one_done", dones, 1);
        chk("count_after_pulse", bus_a.count, 8);

        // Reset mid-measurement aborts with no done and clears results.
        bus_a.ch_sel = 3'd2; bus_a.gate_cycles = 16'd64; bus_a.start_req = 1'b1;
        count_dones(30, dones);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_count", bus_a.count, 0);
        chk("abort_ro_start", ro_start_a, 0);
        chk("abort_busy", bus_a.busy, 0);
        chk("abort_count_b", bus_b.count, 0);
        count_dones(100, cyc);
        chk("abort_no_done", dones + cyc, 0);

`ifdef RO_CONT_MODE_EN
        // Back-to-back windows, then drop cont_mode for one final window.
        bus_a.cont_mode = 1'b1;
        measure(1'b0, 2, 16, cyc);
        chk("cont_first", cyc, 26);
        for (int k = 0; k < 3; k++) begin
            wait_done(1'b0, cyc);
            chk("cont_period", cyc, 17);
            chk("cont_ro_start", ro_start_a, 1);
            chk("cont_count", bus_a.count, 2);
        end
        bus_a.cont_mode = 1'b0;
        wait_done(1'b0, cyc);
        chk("cont_last", cyc, 17);
        chk("cont_idle", bus_a.busy, 0);
        count_dones(40, dones);
        chk("cont_stopped", dones, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
